lfsr: RTL and testbench

LFSR -- requirements
Module: lfsr

---
 rtl/lfsr_pkg.sv | 60 ++++++
 rtl/lfsr.sv | 45 ++++
 tb/tb_lfsr.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and maximal-length tap table for the Fibonacci LFSR.
// Taps follow the XAPP052 table; exponent k lands on state bit k-1.
package lfsr_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Builds a mask from up to four polynomial exponents; 0 marks an unused slot.
  function automatic logic [31:0] taps(input int a, input int b,
                                       input int c = 0, input int d = 0);
    logic [31:0] m;
    m = 32'd0;
    m = m | (32'd1 << (a - 1));
    m = m | (32'd1 << (b - 1));
    if (c > 0) m = m | (32'd1 << (c - 1));
    if (d > 0) m = m | (32'd1 << (d - 1));
    return m;
  endfunction

  function automatic logic [31:0] tap_mask(input int width);
    logic [31:0] m;
    m = 32'd0;
    case (width)
      2:  m = taps(2, 1);
      3:  m = taps(3, 2);
      4:  m = taps(4, 3);
      5:  m = taps(5, 3);
      6:  m = taps(6, 5);
      7:  m = taps(7, 6);
      8:  m = taps(8, 6, 5, 4);
      9:  m = taps(9, 5);
      10: m = taps(10, 7);
      11: m = taps(11, 9);
      12: m = taps(12, 6, 4, 1);
      13: m = taps(13, 4, 3, 1);
      14: m = taps(14, 5, 3, 1);
      15: m = taps(15, 14);
      16: m = taps(16, 15, 13, 4);
      17: m = taps(17, 14);
      18: m = taps(18, 11);
      19: m = taps(19, 6, 2, 1);
      20: m = taps(20, 17);
      21: m = taps(21, 19);
      22: m = taps(22, 21);
      23: m = taps(23, 18);
      24: m = taps(24, 23, 22, 17);
      25: m = taps(25, 22);
      26: m = taps(26, 6, 2, 1);
      27: m = taps(27, 5, 2, 1);
      28: m = taps(28, 25);
      29: m = taps(29, 27);
      30: m = taps(30, 6, 4, 1);
      31: m = taps(31, 28);
      32: m = taps(32, 22, 2, 1);
      default: m = 32'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci XOR LFSR: shifts left with the tap parity fed into bit 0.
// Seeds to all ones on reset and escapes the all-zero lockup state.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o,
  output logic             rnd_o
);

  if (Width < WIDTH_MIN || Width > WIDTH_MAX) begin : g_bad_width
    $error("lfsr: Width must lie in 2..32");
  end

  localparam logic [Width-1:0] TAP_MASK = Width'(tap_mask(Width));
  localparam logic [Width-1:0] SEED     = '1;

  logic [Width-1:0] state_reg;
  logic [Width-1:0] state_next;
  logic             fb;

  assign fb = ^(state_reg & TAP_MASK);

  always_comb begin
    state_next = state_reg;
    if (en_i) begin
      // All-zero is a fixed point of the XOR feedback, so reload the seed.
      if (state_reg == '0) state_next = SEED;
      else                 state_next = {state_reg[Width-2:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= SEED;
    else       state_reg <= state_next;
  end

  assign q_o   = state_reg;
  assign rnd_o = state_reg[Width-1];

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: vector table for Width=5, then period,
// hold, mid-run reset and lockup sequences, plus period checks at 8 and 16.
module tb_lfsr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en5 = 1'b0;
  logic en8 = 1'b0;
  logic en16 = 1'b0;
  logic [4:0]  q5;
  logic [7:0]  q8;
  logic [15:0] q16;
  logic rnd5, rnd8, rnd16;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr #(.Width(5))  dut5  (.clk_i(clk), .rst_i(rst), .en_i(en5),  .q_o(q5),  .rnd_o(rnd5));
  lfsr #(.Width(8))  dut8  (.clk_i(clk), .rst_i(rst), .en_i(en8),  .q_o(q8),  .rnd_o(rnd8));
  lfsr #(.Width(16)) dut16 (.clk_i(clk), .rst_i(rst), .en_i(en16), .q_o(q16), .rnd_o(rnd16));

  typedef struct {
    logic       rst;
    logic       en;
    logic [4:0] q;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seen5;
  logic        seen8[256];
  logic        seen16[65536];
  int          bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'h1F};
    vecs[1]  = '{1'b0, 1'b1, 5'h1E};
    vecs[2]  = '{1'b0, 1'b1, 5'h1C};
    vecs[3]  = '{1'b0, 1'b1, 5'h18};
    vecs[4]  = '{1'b0, 1'b1, 5'h11};
    vecs[5]  = '{1'b0, 1'b1, 5'h03};
    vecs[6]  = '{1'b0, 1'b1, 5'h06};
    vecs[7]  = '{1'b0, 1'b1, 5'h0D};
    vecs[8]  = '{1'b0, 1'b0, 5'h0D};
    vecs[9]  = '{1'b0, 1'b0, 5'h0D};
    vecs[10] = '{1'b0, 1'b1, 5'h1B};
    vecs[11] = '{1'b0, 1'b1, 5'h17};
    vecs[12] = '{1'b1, 1'b1, 5'h1F};
    vecs[13] = '{1'b0, 1'b1, 5'h1E};
    vecs[14] = '{1'b1, 1'b0, 5'h1F};
    vecs[15] = '{1'b0, 1'b0, 5'h1F};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      en5 = vecs[i].en;
      tick();
      check($sformatf("vec%0d q", i), 32'(q5), 32'(vecs[i].q));
      check($sformatf("vec%0d rnd", i), 32'(rnd5), 32'(vecs[i].q[4]));
    end

    // Full period for Width=5 from the seed.
    rst = 1'b1; en5 = 1'b0; tick();
    rst = 1'b0; en5 = 1'b1;
    seen5 = '0; bad = 0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (q5 == 5'd0 || seen5[q5]) bad++;
      seen5[q5] = 1'b1;
    end
    check("w5 period repeats/zero", 32'(bad), 32'd0);
    check("w5 distinct states", 32'(seen5), 32'hFFFF_FFFE);
    check("w5 back to seed at 31", 32'(q5), 32'h1F);

    // Hold mid-sequence: five steps from seed land on 0x03.
    rst = 1'b1; en5 = 1'b0; tick();
    rst = 1'b0; en5 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("hold start", 32'(q5), 32'h03);
    en5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold cycle %0d", i), 32'(q5), 32'h03);
    end
    en5 = 1'b1; tick();
    check("resume after hold", 32'(q5), 32'h06);

    // Reset asserted with enable high after 12 steps.
    rst = 1'b1; en5 = 1'b0; tick();
    rst = 1'b0; en5 = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("step 12", 32'(q5), 32'h1A);
    rst = 1'b1; tick();
    check("mid reset seed", 32'(q5), 32'h1F);
    check("mid reset rnd", 32'(rnd5), 32'd1);
    rst = 1'b0; tick();
    check("restart step 1", 32'(q5), 32'h1E);

    // Lockup escape from a forced all-zero state.
    en5 = 1'b0;
    @(negedge clk);
    force dut5.state_reg = 5'd0;
    #1;
    release dut5.state_reg;
    #1;
    check("lockup forced zero", 32'(q5), 32'h00);
    en5 = 1'b1; tick();
    check("lockup reseed", 32'(q5), 32'h1F);
    en5 = 1'b0;

    // Width=8 and Width=16 periods run side by side.
    rst = 1'b1; tick();
    check("w8 reset", 32'(q8), 32'hFF);
    check("w16 reset", 32'(q16), 32'hFFFF);
    rst = 1'b0; en8 = 1'b1; en16 = 1'b1;
    for (int i = 0; i < 256; i++) seen8[i] = 1'b0;
    for (int i = 0; i < 65536; i++) seen16[i] = 1'b0;
    bad = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i <= 255) begin
        if (q8 == 8'd0 || seen8[q8]) bad++;
        seen8[q8] = 1'b1;
        if (i == 255) begin
          check("w8 repeats/zero", 32'(bad), 32'd0);
          check("w8 back to seed at 255", 32'(q8), 32'hFF);
          bad = 0;
        end
      end else if (i == 256) begin
        en8 = 1'b0;
      end
      if (q16 == 16'd0 || seen16[q16]) bad++;
      seen16[q16] = 1'b1;
    end
    check("w16 repeats/zero", 32'(bad), 32'd0);
    check("w16 back to seed at 65535", 32'(q16), 32'hFFFF);
    check("w16 rnd at seed", 32'(rnd16), 32'd1);
    check("w8 rnd", 32'(rnd8), 32'(q8[7]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
